// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART register map, status bits and packet sender state encoding
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POLL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte offsets of the RS232 UART IP registers, shared with the receive side
    localparam int UART_RX_BASE     = 0;
    localparam int UART_TX_BASE     = 4;
    localparam int UART_STATUS_BASE = 8;

    localparam int UART_TX_OK_BIT = 6;
    localparam int UART_RX_OK_BIT = 7;

    // SYNC + LEN + payload + optional checksum
    function automatic int frame_len(input int payload_bytes, input int checksum_en);
        return 2 + payload_bytes + ((checksum_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_packet_sender_if.sv
// rtl/uart_packet_sender_if.sv - Avalon-MM master bus plus payload handshake of the packet sender
interface uart_packet_sender_if #(
    parameter int PAYLOAD_BYTES = 4
);
    logic [4:0]                   avm_address;
    logic                         avm_read;
    logic [31:0]                  avm_readdata;
    logic                         avm_write;
    logic [31:0]                  avm_writedata;
    logic                         avm_waitrequest;

    logic                         i_valid;
    logic                         o_ready;
    logic [8*PAYLOAD_BYTES-1:0]   i_payload;
    logic                         o_busy;
    logic                         o_done;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest,
        input  i_valid, i_payload,
        output o_ready, o_busy, o_done
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest,
        output i_valid, i_payload,
        input  o_ready, o_busy, o_done
    );
endinterface

// File: rtl/uart_frame_builder.sv
// rtl/uart_frame_builder.sv - combinational frame byte mux over the latched payload
module uart_frame_builder
    import uart_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          CHECKSUM_EN   = 1,
    parameter int          IDX_W         = 3
) (
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic [IDX_W-1:0]           index,
    output logic [7:0]                 frame_byte
);

    localparam int FRAME_LEN = frame_len(PAYLOAD_BYTES, CHECKSUM_EN);

    logic [7:0] checksum;

    // Modulo-256 sum of LEN and every payload byte
    always_comb begin
        checksum = 8'(PAYLOAD_BYTES);
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            checksum = checksum + payload[8*i +: 8];
        end
    end

    // Payload byte 0 is the most-significant byte of the word
    always_comb begin
        frame_byte = SYNC_BYTE;
        if (index == IDX_W'(1)) begin
            frame_byte = 8'(PAYLOAD_BYTES);
        end
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (index == IDX_W'(i + 2)) begin
                frame_byte = payload[8*(PAYLOAD_BYTES-1-i) +: 8];
            end
        end
        if ((CHECKSUM_EN != 0) && (index == IDX_W'(FRAME_LEN - 1))) begin
            frame_byte = checksum;
        end
    end

endmodule

// File: rtl/uart_packet_sender.sv
// rtl/uart_packet_sender.sv - frames a payload word and streams it to the UART over Avalon-MM
module uart_packet_sender
    import uart_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          CHECKSUM_EN   = 1,
    parameter int          TX_BASE       = UART_TX_BASE,
    parameter int          STATUS_BASE   = UART_STATUS_BASE,
    parameter int          TX_OK_BIT     = UART_TX_OK_BIT
) (
    input  logic                  avm_clk,
    input  logic                  avm_rst,
    uart_packet_sender_if.master  bus
);

    localparam int               FRAME_LEN   = frame_len(PAYLOAD_BYTES, CHECKSUM_EN);
    localparam int               IDX_W       = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [4:0]       TX_ADDR     = 5'(TX_BASE);
    localparam logic [4:0]       STATUS_ADDR = 5'(STATUS_BASE);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic                       read_q, read_d;
    logic                       write_q, write_d;
    logic [4:0]                 addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [7:0]                 frame_byte;

    uart_frame_builder #(
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .SYNC_BYTE     (SYNC_BYTE),
        .CHECKSUM_EN   (CHECKSUM_EN),
        .IDX_W         (IDX_W)
    ) u_frame_builder (
        .payload    (payload_q),
        .index      (idx_q),
        .frame_byte (frame_byte)
    );

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            payload_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= STATUS_ADDR;
            wdata_q   <= 32'h0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            payload_q <= payload_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Every bus output is registered, so each branch sets what the bus shows next cycle
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        payload_d = payload_q;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_valid && ready_q) begin
                    payload_d = bus.i_payload;
                    idx_d     = '0;
                    state_d   = POLL;
                    read_d    = 1'b1;
                    addr_d    = STATUS_ADDR;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            POLL: begin
                // TX not ready: leave the read asserted for a back-to-back status read
                if (!bus.avm_waitrequest && bus.avm_readdata[TX_OK_BIT]) begin
                    state_d = WRITE;
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    addr_d  = TX_ADDR;
                    wdata_d = {24'h0, frame_byte};
                end
            end

            WRITE: begin
                if (!bus.avm_waitrequest) begin
                    write_d = 1'b0;
                    addr_d  = STATUS_ADDR;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        read_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = POLL;
                        read_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.avm_address   = addr_q;
    assign bus.avm_read      = read_q;
    assign bus.avm_write     = write_q;
    assign bus.avm_writedata = wdata_q;
    assign bus.o_ready       = ready_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;

endmodule

// File: tb/tb_uart_packet_sender.sv
// tb/tb_uart_packet_sender.sv - directed self-checking bench with a polled UART responder model
module tb_uart_packet_sender;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    uart_packet_sender_if #(.PAYLOAD_BYTES(4)) a_if ();
    uart_packet_sender_if #(.PAYLOAD_BYTES(1)) b_if ();

    uart_packet_sender u_a (
        .avm_clk (clk),
        .avm_rst (rst_a),
        .bus     (a_if.master)
    );

    uart_packet_sender #(
        .PAYLOAD_BYTES (1),
        .CHECKSUM_EN   (0)
    ) u_b (
        .avm_clk (clk),
        .avm_rst (rst_b),
        .bus     (b_if.master)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] log_a[$];
    logic [7:0] log_b[$];
    int         done_cnt_a = 0;
    int         done_cnt_b = 0;
    int         reads_a = 0;
    int         proto_err_a = 0;
    int         proto_err_b = 0;
    int         poll_stall_a = 0;
    int         polls_left_a = 0;
    int         stall_left_a = 0;
    int         stall_cycles_a = 0;
    logic [7:0] stall_byte_a = 8'h00;
    bit         ok_seen_a = 1'b0;

    // UART model for instance A: answers at the falling edge for the next rising edge
    always @(negedge clk) begin
        a_if.avm_waitrequest = 1'b0;
        a_if.avm_readdata    = 32'h0;
        if (rst_a) begin
            ok_seen_a = 1'b0;
        end else begin
            if (a_if.o_done) done_cnt_a++;
            if (a_if.avm_read && a_if.avm_write) proto_err_a++;
            if (a_if.avm_read) begin
                reads_a++;
                if (a_if.avm_address != 5'd8) proto_err_a++;
                if (polls_left_a > 0) begin
                    polls_left_a--;
                end else begin
                    a_if.avm_readdata = 32'h0000_0040;
                    ok_seen_a = 1'b1;
                end
            end
            if (a_if.avm_write) begin
                if (a_if.avm_address != 5'd4 || !ok_seen_a || a_if.avm_writedata[31:8] != 24'h0)
                    proto_err_a++;
                if (stall_left_a > 0 && a_if.avm_writedata[7:0] == stall_byte_a) begin
                    a_if.avm_waitrequest = 1'b1;
                    stall_left_a--;
                    stall_cycles_a++;
                end else begin
                    log_a.push_back(a_if.avm_writedata[7:0]);
                    ok_seen_a = 1'b0;
                    polls_left_a = poll_stall_a;
                end
            end
        end
    end

    // UART model for instance B: always ready, never stalls
    always @(negedge clk) begin
        b_if.avm_waitrequest = 1'b0;
        b_if.avm_readdata    = 32'h0000_0040;
        if (!rst_b) begin
            if (b_if.o_done) done_cnt_b++;
            if (b_if.avm_read && b_if.avm_write) proto_err_b++;
            if (b_if.avm_read && b_if.avm_address != 5'd8) proto_err_b++;
            if (b_if.avm_write) begin
                if (b_if.avm_address != 5'd4 || b_if.avm_writedata[31:8] != 24'h0) proto_err_b++;
                log_b.push_back(b_if.avm_writedata[7:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
        end
    endtask

    // Called on a falling edge; returns one falling edge after the accept edge
    task automatic send_a(input string tag, input logic [31:0] payload);
        a_if.i_payload = payload;
        a_if.i_valid   = 1'b1;
        @(negedge clk);
        chk({tag, "_read_after_accept"}, a_if.avm_read, 1'b1);
        chk({tag, "_busy_after_accept"}, a_if.o_busy, 1'b1);
        a_if.i_valid   = 1'b0;
        a_if.i_payload = ~payload;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!a_if.o_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, a_if.o_done, 1'b1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, a_if.o_done, 1'b0);
        chk({tag, "_busy_low"}, a_if.o_busy, 1'b0);
        chk({tag, "_ready_high"}, a_if.o_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] exp[$];
        int         n;

        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.i_valid = 1'b0;
        a_if.i_payload = 32'h0;
        b_if.i_valid = 1'b0;
        b_if.i_payload = 8'h0;
        repeat (3) @(negedge clk);

        chk("rst_read", a_if.avm_read, 1'b0);
        chk("rst_write", a_if.avm_write, 1'b0);
        chk("rst_address", a_if.avm_address, 5'd8);
        chk("rst_writedata", a_if.avm_writedata, 32'h0);
        chk("rst_ready", a_if.o_ready, 1'b1);
        chk("rst_busy", a_if.o_busy, 1'b0);
        chk("rst_done", a_if.o_done, 1'b0);
        chk("rst_b_ready", b_if.o_ready, 1'b1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Basic frame; checksum 04+22+77+C1+05 = 0x163 -> 63
        log_a.delete(); done_cnt_a = 0; reads_a = 0; proto_err_a = 0;
        send_a("basic", 32'h2277C105);
        wait_done_a("basic");
        exp = '{8'hA5, 8'h04, 8'h22, 8'h77, 8'hC1, 8'h05, 8'h63};
        check_log("basic", log_a, exp);
        chk("basic_done_count", done_cnt_a, 1);
        chk("basic_reads", reads_a, 7);
        chk("basic_proto", proto_err_a, 0);

        // Ten not-ready status reads before every byte
        log_a.delete(); done_cnt_a = 0; reads_a = 0; proto_err_a = 0;
        poll_stall_a = 10; polls_left_a = 10;
        send_a("txok", 32'h2277C105);
        wait_done_a("txok");
        check_log("txok", log_a, exp);
        chk("txok_reads", reads_a, 77);
        chk("txok_proto", proto_err_a, 0);
        chk("txok_done_count", done_cnt_a, 1);
        poll_stall_a = 0; polls_left_a = 0;

        // waitrequest held for three cycles on the 0x77 write
        log_a.delete(); done_cnt_a = 0; proto_err_a = 0; stall_cycles_a = 0;
        stall_byte_a = 8'h77; stall_left_a = 3;
        send_a("wreq", 32'h2277C105);
        wait_done_a("wreq");
        check_log("wreq", log_a, exp);
        chk("wreq_stall_cycles", stall_cycles_a, 3);
        chk("wreq_proto", proto_err_a, 0);

        // One-byte payload without checksum on instance B
        log_b.delete(); done_cnt_b = 0; proto_err_b = 0;
        b_if.i_payload = 8'hFF;
        b_if.i_valid   = 1'b1;
        @(negedge clk);
        chk("b_busy", b_if.o_busy, 1'b1);
        b_if.i_valid = 1'b0;
        n = 0;
        while (!b_if.o_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_seen", b_if.o_done, 1'b1);
        @(negedge clk);
        exp = '{8'hA5, 8'h01, 8'hFF};
        check_log("b_frame", log_b, exp);
        chk("b_done_count", done_cnt_b, 1);
        chk("b_proto", proto_err_b, 0);

        // i_valid held: second payload waits for DONE, then IDLE for exactly one cycle
        log_a.delete(); done_cnt_a = 0; proto_err_a = 0;
        a_if.i_payload = 32'h01020304;
        a_if.i_valid   = 1'b1;
        @(negedge clk);
        chk("hold_first_read", a_if.avm_read, 1'b1);
        a_if.i_payload = 32'hA0B0C0D0;
        n = 0;
        while (!a_if.o_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("hold_done1_seen", a_if.o_done, 1'b1);
        @(negedge clk);
        chk("hold_idle_ready", a_if.o_ready, 1'b1);
        chk("hold_idle_busy", a_if.o_busy, 1'b0);
        @(negedge clk);
        chk("hold_second_read", a_if.avm_read, 1'b1);
        chk("hold_second_busy", a_if.o_busy, 1'b1);
        a_if.i_valid = 1'b0;
        wait_done_a("hold2");
        exp = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E,
                8'hA5, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE4};
        check_log("hold", log_a, exp);
        chk("hold_done_count", done_cnt_a, 2);
        chk("hold_proto", proto_err_a, 0);

        // Reset while polling for frame byte 3
        log_a.delete(); done_cnt_a = 0; proto_err_a = 0;
        poll_stall_a = 5; polls_left_a = 5;
        send_a("abort", 32'h2277C105);
        n = 0;
        while (!(log_a.size() == 3 && a_if.avm_read) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_poll3", (log_a.size() == 3 && a_if.avm_read) ? 1 : 0, 1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("abort_read", a_if.avm_read, 1'b0);
        chk("abort_write", a_if.avm_write, 1'b0);
        chk("abort_ready", a_if.o_ready, 1'b1);
        chk("abort_busy", a_if.o_busy, 1'b0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt_a, 0);
        chk("abort_no_more_bytes", log_a.size(), 3);
        chk("abort_idle_read", a_if.avm_read, 1'b0);

        log_a.delete(); proto_err_a = 0;
        poll_stall_a = 0; polls_left_a = 0;
        send_a("fresh", 32'h01020304);
        wait_done_a("fresh");
        exp = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        check_log("fresh", log_a, exp);
        chk("fresh_done_count", done_cnt_a, 1);
        chk("fresh_proto", proto_err_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
